// File: rtl/sr_rx_deser_if.sv
// Serial-in / parallel-out bundle for sr_rx_deser; master is the receiver side,
// slave is the bit source plus the parallel-word consumer.
interface sr_rx_deser_if #(parameter int n = 8);
  logic         s_in;
  logic         s_en;
  logic         sync;
  logic         p_ack;
  logic [n-1:0] p_out;
  logic         p_valid;
  logic         overrun;
  logic         busy;
  logic         parity_err;

  modport master (
    input  s_in, s_en, sync, p_ack,
    output p_out, p_valid, overrun, busy, parity_err
  );

  modport slave (
    output s_in, s_en, sync, p_ack,
    input  p_out, p_valid, overrun, busy, parity_err
  );
endinterface

// File: rtl/sr_rx_deser.sv
// MSB-first serial-to-parallel receiver with valid/ack handshake and sticky overrun.
// Define SR_RX_PARITY_EN to expect a trailing even-parity bit after every word.
module sr_rx_deser #(
  parameter int n = 8
) (
  input  logic          clk,
  input  logic          rst,
  sr_rx_deser_if.master bus
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

`ifdef SR_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t        state;
  logic [n-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [n-1:0]  out_q;
  logic          valid_q;
  logic          overrun_q;
`ifdef SR_RX_PARITY_EN
  logic          perr_q;
`endif

  // An ack in the same cycle as a completion still counts, so the completion
  // path below overrides the ack's clear of valid but leaves overrun at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SR_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      if (valid_q && bus.p_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      if (bus.sync) begin
        sh    <= bus.s_en ? {{(n-1){1'b0}}, bus.s_in} : '0;
        cnt   <= bus.s_en ? CW'(1) : '0;
        state <= bus.s_en ? SHIFT : IDLE;
      end else if (bus.s_en) begin
`ifdef SR_RX_PARITY_EN
        if (state == PAR) begin
          out_q   <= sh;
          perr_q  <= ^{sh, bus.s_in};
          valid_q <= 1'b1;
          if (valid_q) overrun_q <= !bus.p_ack;
          cnt     <= '0;
          state   <= IDLE;
        end else begin
          sh    <= {sh[n-2:0], bus.s_in};
          cnt   <= cnt + CW'(1);
          state <= (state == SHIFT && cnt == LAST) ? PAR : SHIFT;
        end
`else
        sh <= {sh[n-2:0], bus.s_in};
        if (state == SHIFT && cnt == LAST) begin
          out_q   <= {sh[n-2:0], bus.s_in};
          valid_q <= 1'b1;
          if (valid_q) overrun_q <= !bus.p_ack;
          cnt     <= '0;
          state   <= IDLE;
        end else begin
          cnt   <= cnt + CW'(1);
          state <= SHIFT;
        end
`endif
      end
    end
  end

  assign bus.p_out   = out_q;
  assign bus.p_valid = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (cnt != '0);
`ifdef SR_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
